codemem_loader: RTL and testbench

//  Programs the 64x16 code memory from a byte stream, acting as the write-side master of the

---
 rtl/codemem_loader.sv | 96 +++++++++
 tb/tb_codemem_loader.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/codemem_loader.sv
// codemem_loader: packs a byte stream into 16-bit words and writes them to code memory from address 0,
// holding the CPU off while loading.
module codemem_loader #(
  parameter int ADDR_W = 6,
  parameter int WORD_W = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W:0]   word_count,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  input  logic              run_req,
  output logic              c1,
  output logic [ADDR_W-1:0] write_select,
  output logic [WORD_W-1:0] inp,
  output logic              mem_run,
  output logic              busy,
  output logic              done,
  output logic              error
);
  typedef enum logic [2:0] {IDLE, LOAD_HI, LOAD_LO, WRITE, DONE} state_t;
  localparam logic [ADDR_W:0] MAX = (ADDR_W+1)'(2**ADDR_W);
  state_t            state;
  logic [ADDR_W:0]   count;
  logic [ADDR_W-1:0] addr;
  logic [7:0]        hi;
  logic              legal, last;
  assign legal = (word_count != '0) && (word_count <= MAX);
  assign last = {1'b0, addr} == count - 1'b1;
  assign mem_run = !reset && ((state == WRITE) || ((state == IDLE || state == DONE) && run_req));
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      count <= '0;
      addr <= '0;
      hi <= '0;
      c1 <= 1'b0;
      write_select <= '0;
      inp <= '0;
      byte_ready <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
      error <= 1'b0;
    end else if (abort && busy) begin
      state <= IDLE;
      c1 <= 1'b0;
      done <= 1'b0;
      busy <= 1'b0;
      byte_ready <= 1'b0;
    end else begin
      case (state)
        IDLE, DONE: if (start && !abort) begin
          done <= 1'b0;
          if (legal) begin
            count <= word_count;
            addr <= '0;
            error <= 1'b0;
            state <= LOAD_HI;
            busy <= 1'b1;
            byte_ready <= 1'b1;
          end else begin
            error <= 1'b1;
            state <= IDLE;
          end
        end
        LOAD_HI: if (byte_valid) begin
          hi <= byte_data;
          state <= LOAD_LO;
        end
        LOAD_LO: if (byte_valid) begin
          inp <= {hi, byte_data};
          write_select <= addr;
          c1 <= 1'b1;
          byte_ready <= 1'b0;
          state <= WRITE;
        end
        WRITE: begin
          c1 <= 1'b0;
          if (last) begin
            state <= DONE;
            done <= 1'b1;
            busy <= 1'b0;
          end else begin
            addr <= addr + 1'b1;
            byte_ready <= 1'b1;
            state <= LOAD_HI;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_codemem_loader.sv
// tb_codemem_loader: vector table plus directed sequences against a code-memory write model.
module tb_codemem_loader;
  logic clock = 0, reset = 1, start = 0, abort = 0, byte_valid = 0, run_req = 0;
  logic [6:0] word_count = '0;
  logic [7:0] byte_data = '0;
  logic byte_ready, c1, mem_run, busy, done, error;
  logic [5:0] write_select;
  logic [15:0] inp;
  int checks = 0, errors = 0, wr_cnt = 0, dbl = 0, w0;
  logic c1_prev = 0;
  logic [15:0] mem [64];

  codemem_loader dut (
    .clock(clock), .reset(reset), .start(start), .abort(abort), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready), .run_req(run_req),
    .c1(c1), .write_select(write_select), .inp(inp), .mem_run(mem_run), .busy(busy),
    .done(done), .error(error)
  );

  always #5 clock = ~clock;

  // code memory model: captures a word on every posedge where c1 is high
  always @(posedge clock) begin
    if (c1) begin
      mem[write_select] = inp;
      wr_cnt++;
      if (c1_prev) dbl++;
    end
    c1_prev = c1;
  end

  typedef struct {
    logic st, ab;
    logic [6:0] wc;
    logic bv;
    logic [7:0] bd;
    logic rr;
    logic [27:0] exp;
  } vec_t;
  vec_t vecs [21];

  function automatic vec_t v(logic st, ab, logic [6:0] wc, logic bv, logic [7:0] bd, logic rr,
                             logic ec1, logic [5:0] ews, logic [15:0] einp,
                             logic ebr, ebusy, edone, eerr, emr);
    vec_t r;
    r.st = st; r.ab = ab; r.wc = wc; r.bv = bv; r.bd = bd; r.rr = rr;
    r.exp = {ec1, ews, einp, ebr, ebusy, edone, eerr, emr};
    return r;
  endfunction

  function automatic logic [27:0] outs();
    return {c1, write_select, inp, byte_ready, busy, done, error, mem_run};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic start_load(input logic [6:0] n);
    start = 1; word_count = n;
    @(negedge clock);
    start = 0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    byte_valid = 1; byte_data = b;
    while (!byte_ready && n < 20) begin
      @(negedge clock);
      n++;
    end
    if (!byte_ready) chk("byte_ready_timeout", 0, 1);
    @(negedge clock);
    byte_valid = 0;
  endtask

  task automatic wait_done(input string name);
    int n = 0;
    while (!done && n < 20) begin
      @(negedge clock);
      n++;
    end
    chk(name, done, 1);
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    //            st ab wc     bv bd     rr  c1 ws  inp        br bsy dn er mr
    vecs[0]  = v(1, 0, 7'd2,  0, 8'h00, 0,  0, 0, 16'h0000,  1, 1,  0, 0, 0);
    vecs[1]  = v(0, 0, 7'd0,  1, 8'h12, 0,  0, 0, 16'h0000,  1, 1,  0, 0, 0);
    vecs[2]  = v(0, 0, 7'd0,  1, 8'h34, 0,  1, 0, 16'h1234,  0, 1,  0, 0, 1);
    vecs[3]  = v(0, 0, 7'd0,  1, 8'h56, 0,  0, 0, 16'h1234,  1, 1,  0, 0, 0);
    vecs[4]  = v(0, 0, 7'd0,  1, 8'h56, 0,  0, 0, 16'h1234,  1, 1,  0, 0, 0);
    vecs[5]  = v(0, 0, 7'd0,  1, 8'h78, 0,  1, 1, 16'h5678,  0, 1,  0, 0, 1);
    vecs[6]  = v(0, 0, 7'd0,  0, 8'h00, 1,  0, 1, 16'h5678,  0, 0,  1, 0, 1);
    vecs[7]  = v(0, 0, 7'd0,  0, 8'h00, 0,  0, 1, 16'h5678,  0, 0,  1, 0, 0);
    vecs[8]  = v(1, 0, 7'd0,  0, 8'h00, 0,  0, 1, 16'h5678,  0, 0,  0, 1, 0);
    vecs[9]  = v(1, 0, 7'd65, 0, 8'h00, 1,  0, 1, 16'h5678,  0, 0,  0, 1, 1);
    vecs[10] = v(1, 0, 7'd1,  0, 8'h00, 0,  0, 1, 16'h5678,  1, 1,  0, 0, 0);
    vecs[11] = v(0, 0, 7'd0,  1, 8'hAB, 0,  0, 1, 16'h5678,  1, 1,  0, 0, 0);
    vecs[12] = v(0, 0, 7'd0,  0, 8'h00, 0,  0, 1, 16'h5678,  1, 1,  0, 0, 0);
    vecs[13] = v(1, 0, 7'd5,  0, 8'h00, 0,  0, 1, 16'h5678,  1, 1,  0, 0, 0);
    vecs[14] = v(0, 0, 7'd0,  0, 8'h00, 1,  0, 1, 16'h5678,  1, 1,  0, 0, 0);
    vecs[15] = v(0, 0, 7'd0,  0, 8'h00, 1,  0, 1, 16'h5678,  1, 1,  0, 0, 0);
    vecs[16] = v(0, 0, 7'd0,  0, 8'h00, 1,  0, 1, 16'h5678,  1, 1,  0, 0, 0);
    vecs[17] = v(0, 0, 7'd0,  1, 8'hCD, 0,  1, 0, 16'hABCD,  0, 1,  0, 0, 1);
    vecs[18] = v(0, 0, 7'd0,  0, 8'h00, 0,  0, 0, 16'hABCD,  0, 0,  1, 0, 0);
    vecs[19] = v(1, 0, 7'd3,  0, 8'h00, 0,  0, 0, 16'hABCD,  1, 1,  0, 0, 0);
    vecs[20] = v(1, 1, 7'd3,  0, 8'h00, 0,  0, 0, 16'hABCD,  0, 0,  0, 0, 0);

    #1 chk("reset_outputs", outs(), 28'h0);
    @(negedge clock);
    reset = 0;
    for (int k = 0; k < 21; k++) begin
      start = vecs[k].st; abort = vecs[k].ab; word_count = vecs[k].wc;
      byte_valid = vecs[k].bv; byte_data = vecs[k].bd; run_req = vecs[k].rr;
      @(negedge clock);
      chk($sformatf("vec%0d", k), outs(), vecs[k].exp);
    end
    start = 0; abort = 0; byte_valid = 0; run_req = 0; word_count = '0;
    chk("t1_writes", wr_cnt, 3);
    chk("t4_mem0", mem[0], 16'hABCD);
    chk("t1_mem1", mem[1], 16'h5678);

    w0 = wr_cnt;
    start_load(7'd64);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i);
      send_byte(b);
      send_byte(~b);
    end
    wait_done("t2_done");
    chk("t2_writes", wr_cnt - w0, 64);
    for (int i = 0; i < 64; i++) begin
      logic [7:0] b;
      b = 8'(i);
      chk($sformatf("t2_mem%0d", i), mem[i], {b, ~b});
    end

    w0 = wr_cnt;
    start_load(7'd6);
    for (int i = 0; i < 3; i++) begin
      send_byte(8'hA0 + 8'(i));
      send_byte(8'h50 + 8'(i));
    end
    send_byte(8'hEE);
    abort = 1;
    @(negedge clock);
    abort = 0; run_req = 1; byte_valid = 1; byte_data = 8'h77;
    #1;
    chk("t5_busy", busy, 0);
    chk("t5_done", done, 0);
    chk("t5_run", mem_run, 1);
    repeat (4) @(negedge clock);
    byte_valid = 0; run_req = 0;
    chk("t5_writes", wr_cnt - w0, 3);
    chk("t5_mem2", mem[2], 16'hA252);
    chk("t5_mem3", mem[3], 16'h03FC);

    start_load(7'd2);
    send_byte(8'h99);
    run_req = 1;
    #2 reset = 1;
    #1 chk("t6_reset", outs(), 28'h0);
    @(negedge clock);
    reset = 0; run_req = 0;
    w0 = wr_cnt;
    start_load(7'd1);
    send_byte(8'h5A);
    send_byte(8'hA5);
    wait_done("t6_done");
    chk("t6_writes", wr_cnt - w0, 1);
    chk("t6_mem0", mem[0], 16'h5AA5);
    chk("t6_error", error, 0);
    chk("c1_single_cycle", dbl, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
